// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the transmitter (and the future receiver):
//   parity_t    - parity mode selection (NONE / EVEN / ODD)
//   tx_state_t  - transmitter frame sequencing states
//   calc_baud_div - clock cycles per bit, truncated division
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_t;

  // State names carry a TX_ prefix so they never collide with the PARITY
  // parameter of modules that import this package.
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 9;

  // Clock cycles per serial bit; fractional part is dropped.
  function automatic int unsigned calc_baud_div(input int unsigned clk_hz,
                                                input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. dout always presents the head entry, so a pop
// consumes the word visible in the same cycle.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset (flushes contents)
//   push, din     - write request and data (ignored while full)
//   pop, dout     - read request and head data (ignored while empty)
//   full, empty   - occupancy flags, decoded from the count register
//   count         - number of stored words, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push && (r_count != FULL_COUNT);
  assign w_do_pop  = pop  && (r_count != (AW+1)'(0));

  // Storage array, written on accepted pushes only (no reset needed).
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= (AW+1)'(0);
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == FULL_COUNT);
  assign empty = (r_count == (AW+1)'(0));
  assign count = r_count;

endmodule

// File: rtl/uart_tx_stream.sv
// -----------------------------------------------------------------------------
// uart_tx_stream
// Buffered UART transmitter. Words enter a FIFO over a valid/ready stream and
// are serialised LSB first as start / data / optional parity / stop bits.
// Frames follow each other with no idle gap while the FIFO holds data.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   tx_data     - word to send (DATA_BITS wide)
//   tx_valid    - tx_data valid; accepted when tx_valid && tx_ready at an edge
//   tx_ready    - registered, low while the FIFO is full and during reset
//   uart_tx     - registered serial line, idle high
//   busy        - registered: frame in progress or words still queued
//   fifo_count  - queued words, excluding the frame currently on the line
// -----------------------------------------------------------------------------
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY_HZ = 100_000_000,
  parameter int unsigned BAUD             = 9600,
  parameter int          DATA_BITS        = 8,
  parameter parity_t     PARITY           = PARITY_NONE,
  parameter int          STOP_BITS        = 1,
  parameter int          FIFO_DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BAUD_DIV = calc_baud_div(CLK_FREQUENCY_HZ, BAUD);
  localparam int CNT_W = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0]    FULL_COUNT = CW'(FIFO_DEPTH);

  // Elaboration-time parameter legality checks.
  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_tx_stream: BAUD_DIV must be at least 2");
  end
  if ((DATA_BITS < MIN_DATA_BITS) || (DATA_BITS > MAX_DATA_BITS)) begin : g_bad_data
    $error("uart_tx_stream: DATA_BITS must be within 5..9");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
    $error("uart_tx_stream: STOP_BITS must be 1 or 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_stream: FIFO_DEPTH must be a power of two and at least 2");
  end

  // Parity bit of a payload word for the configured mode (unused for NONE).
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    if (PARITY == PARITY_ODD) begin
      return ~^d;
    end else begin
      return ^d;
    end
  endfunction

  // FIFO interface
  logic                 w_push;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_fifo_dout;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [CW-1:0]        w_fifo_count;
  logic [CW-1:0]        w_fifo_count_next;

  // Frame engine state
  tx_state_t            r_state;
  tx_state_t            w_state_next;
  logic [CNT_W-1:0]     r_baud_cnt;
  logic [CNT_W-1:0]     w_baud_cnt_next;
  logic [3:0]           r_bit_cnt;
  logic [3:0]           w_bit_cnt_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 r_parity_bit;
  logic                 w_parity_bit_next;
  logic                 w_baud_tick;
  logic                 w_line;

  // Registered outputs
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_ready;

  assign w_push = tx_valid && r_ready;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (tx_data),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  assign w_fifo_count_next = w_fifo_count + CW'(w_push) - CW'(w_pop);
  assign w_baud_tick       = (r_baud_cnt == BAUD_LAST);

  // Frame sequencing: next state, counters, shift register and FIFO pop.
  always_comb begin
    w_state_next      = r_state;
    w_baud_cnt_next   = r_baud_cnt;
    w_bit_cnt_next    = r_bit_cnt;
    w_shift_next      = r_shift;
    w_parity_bit_next = r_parity_bit;
    w_pop             = 1'b0;

    case (r_state)
      TX_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop             = 1'b1;
          w_shift_next      = w_fifo_dout;
          w_parity_bit_next = parity_of(w_fifo_dout);
          w_baud_cnt_next   = CNT_W'(0);
          w_bit_cnt_next    = 4'd0;
          w_state_next      = TX_START;
        end else begin
          w_state_next = TX_IDLE;
        end
      end

      TX_START: begin
        if (w_baud_tick) begin
          w_baud_cnt_next = CNT_W'(0);
          w_bit_cnt_next  = 4'd0;
          w_state_next    = TX_DATA;
        end else begin
          w_baud_cnt_next = r_baud_cnt + CNT_W'(1);
        end
      end

      TX_DATA: begin
        if (w_baud_tick) begin
          w_baud_cnt_next = CNT_W'(0);
          w_shift_next    = r_shift >> 1;
          if (r_bit_cnt == DATA_LAST) begin
            w_bit_cnt_next = 4'd0;
            if (PARITY == PARITY_NONE) begin
              w_state_next = TX_STOP;
            end else begin
              w_state_next = TX_PARITY;
            end
          end else begin
            w_bit_cnt_next = r_bit_cnt + 4'd1;
          end
        end else begin
          w_baud_cnt_next = r_baud_cnt + CNT_W'(1);
        end
      end

      TX_PARITY: begin
        if (w_baud_tick) begin
          w_baud_cnt_next = CNT_W'(0);
          w_bit_cnt_next  = 4'd0;
          w_state_next    = TX_STOP;
        end else begin
          w_baud_cnt_next = r_baud_cnt + CNT_W'(1);
        end
      end

      TX_STOP: begin
        if (w_baud_tick) begin
          w_baud_cnt_next = CNT_W'(0);
          if (r_bit_cnt == STOP_LAST) begin
            w_bit_cnt_next = 4'd0;
            // Chain straight into the next frame when more data is queued.
            if (!w_fifo_empty) begin
              w_pop             = 1'b1;
              w_shift_next      = w_fifo_dout;
              w_parity_bit_next = parity_of(w_fifo_dout);
              w_state_next      = TX_START;
            end else begin
              w_state_next = TX_IDLE;
            end
          end else begin
            w_bit_cnt_next = r_bit_cnt + 4'd1;
          end
        end else begin
          w_baud_cnt_next = r_baud_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_next    = TX_IDLE;
        w_baud_cnt_next = CNT_W'(0);
        w_bit_cnt_next  = 4'd0;
      end
    endcase
  end

  // Line level implied by the current state; registered one cycle later.
  always_comb begin
    case (r_state)
      TX_IDLE:   w_line = 1'b1;
      TX_START:  w_line = 1'b0;
      TX_DATA:   w_line = r_shift[0];
      TX_PARITY: w_line = r_parity_bit;
      TX_STOP:   w_line = 1'b1;
      default:   w_line = 1'b1;
    endcase
  end

  // Frame engine registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= TX_IDLE;
      r_baud_cnt   <= CNT_W'(0);
      r_bit_cnt    <= 4'd0;
      r_shift      <= DATA_BITS'(0);
      r_parity_bit <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_baud_cnt   <= w_baud_cnt_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_shift      <= w_shift_next;
      r_parity_bit <= w_parity_bit_next;
    end
  end

  // Output registers. Ready drops on the edge that fills the FIFO and only
  // returns one edge after a pop has freed a slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_tx    <= w_line;
      r_busy  <= (w_state_next != TX_IDLE) || (w_fifo_count_next != CW'(0));
      r_ready <= (w_fifo_count_next != FULL_COUNT) && !w_fifo_full;
    end
  end

  assign uart_tx    = r_tx;
  assign busy       = r_busy;
  assign tx_ready   = r_ready;
  assign fifo_count = w_fifo_count;

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Buffered, parametrised UART transmitter for the SoC peripheral bus. It accepts words through a valid/ready stream into an internal FIFO and serialises them LSB-first. Data width, parity, stop bits and FIFO depth are configurable. Frames are sent back-to-back while the FIFO holds data, so the CPU-side driver can queue a burst without polling per byte.

## Interface
- CLK_FREQUENCY_HZ, 100_000_000 (SIMULATION: 20): input clock frequency.
- BAUD, 9600 (SIMULATION: 2): line rate; BAUD_DIV = CLK_FREQUENCY_HZ / BAUD, truncated.
- DATA_BITS, 8: payload bits per frame, legal 5..9.
- PARITY, PARITY_NONE: uart_pkg::parity_t, one of NONE / EVEN / ODD.
- STOP_BITS, 1: legal 1..2.
- FIFO_DEPTH, 16: power of two, ≥ 2.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  DATA_BITS  word to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  FIFO can accept; transfer when tx_valid && tx_ready at a rising edge.
- uart_tx  out  1  serial line, idle high.
- busy  out  1  FSM not IDLE, or FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words queued, not including the frame in flight.

## Operation
- Reset, asynchronous, takes effect immediately:
  - uart_tx=1, busy=0, tx_ready=0 while rst is high, fifo_count=0.
  - FSM goes to IDLE and the FIFO is flushed.
  - tx_ready=1 from the first edge after release.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when FIFO non-empty, pop the head into the shift register, clear the baud and bit counters, go to START.
- START: line 0 for BAUD_DIV cycles, then DATA.
- DATA: line = shift[0] for BAUD_DIV cycles per bit, LSB first, DATA_BITS bits.
  - After the last bit: go to PARITY, or to STOP when PARITY_NONE.
- PARITY: line = ^data for EVEN, ~^data for ODD; held BAUD_DIV cycles.
- STOP: line 1 for STOP_BITS×BAUD_DIV cycles.
  - At the end: if FIFO non-empty, pop and go directly to START with no idle gap; else go to IDLE.
- Baud counter runs 0..BAUD_DIV-1 and restarts at every frame start, so every bit lasts exactly BAUD_DIV cycles.
  - Frame length = BAUD_DIV×(1+DATA_BITS+(PARITY≠NONE)+STOP_BITS) cycles.
- FIFO rules:
  - tx_ready = !full, registered from the count.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - A push while full cannot occur, because ready is low.
  - A pop while empty never occurs.
- uart_tx is a registered output with no combinational path from inputs.
- Elaboration error if any of these hold: BAUD_DIV < 2, DATA_BITS outside 5..9, STOP_BITS outside 1..2, FIFO_DEPTH not a power of two.

## Timing
- Accepting edge E with the FIFO empty and FSM in IDLE:
  - fifo_count=1 after E.
  - Pop at E+1, fifo_count=0.
  - uart_tx falls at E+2.
- busy rises after E; falls on the edge that ends the final stop bit with the FIFO empty.
- When full, tx_ready rises on the edge after the pop that frees a slot.
- Reset asserted mid-frame: line returns high at once, the partial frame is abandoned and the queued words are lost.

## Structure
- Package uart_pkg: parity_t enum, tx_state_t enum {IDLE, START, DATA, PARITY, STOP}, and a function computing BAUD_DIV. The package is shared with the future receiver.
- Sub-module sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - Async active-high reset.
  - Reusable by the receiver.
- Top level holds the FSM, the baud counter, the bit counter and the shift register.

## Test plan
All scenarios use SIMULATION parameters (BAUD_DIV=10).
- 0xA5, PARITY_NONE, STOP_BITS=1 into an idle block -> uart_tx low for cycles E+2..E+11, then bits 1,0,1,0,0,1,0,1 for 10 cycles each, stop high 10 cycles; busy low after cycle E+101.
- 0x07 with EVEN -> parity bit 1; with ODD -> parity bit 0; STOP_BITS=2 -> stop high 20 cycles, frame 120 cycles.
- FIFO_DEPTH=4, frame in flight, tx_valid held high -> exactly 4 further words accepted, tx_ready=0 with fifo_count=4; tx_ready=1 one edge after the next pop.
- Push 0x00 then 0xFF -> second start bit begins on the cycle after the first stop bit ends; both frames total 200 cycles with no idle gap.
- rst pulsed during data bit 3 with 2 words queued -> uart_tx=1 and fifo_count=0 immediately; line stays high after release until a new push.
- DATA_BITS=5, 0x13, ODD -> bits 1,1,0,0,1, then parity 0, then stop; frame 80 cycles.
